// File: rtl/deadtime_generator_pkg.sv
// Shared definitions for the buck power-stage gate driver.
// State encoding is fixed so debug captures decode consistently.
package deadtime_generator_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        OFF     = 3'd0,
        DT_LH   = 3'd1,
        HIGH_ON = 3'd2,
        DT_HL   = 3'd3,
        LOW_ON  = 3'd4,
        FAULT   = 3'd5
    } state_t;

endpackage

// File: rtl/deadtime_generator.sv
// Complementary high/low gate drive from a single PWM, with programmable
// dead time per edge, a latched fault shutdown and an enable gate.
module deadtime_generator
    import deadtime_generator_pkg::*;
#(
    parameter int deadtime_width = 8,
    parameter int min_deadtime   = 1
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      pwm,
    input  logic [deadtime_width-1:0] deadtime_rise,
    input  logic [deadtime_width-1:0] deadtime_fall,
    input  logic                      fault,
    input  logic                      fault_clear,
    output logic                      pwm_h,
    output logic                      pwm_l,
    output logic                      fault_latched,
    output logic [STATE_W-1:0]        state
);

    localparam int W = deadtime_width;
    localparam logic [W-1:0] MIN_DT = W'(min_deadtime);

    state_t          r_state;
    logic            r_pwm_q;
    logic [W-1:0]    r_cnt;
    logic            r_pwm_h;
    logic            r_pwm_l;
    logic            r_fault;
    logic [W-1:0]    w_rise_load;
    logic [W-1:0]    w_fall_load;

    // Counter is loaded with D-1 so the dead state lasts exactly D cycles
    always_comb begin
        w_rise_load = ((deadtime_rise < MIN_DT) ? MIN_DT : deadtime_rise) - W'(1);
        w_fall_load = ((deadtime_fall < MIN_DT) ? MIN_DT : deadtime_fall) - W'(1);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= OFF;
            r_pwm_q <= 1'b0;
            r_cnt   <= '0;
            r_pwm_h <= 1'b0;
            r_pwm_l <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_pwm_q <= pwm;
            r_pwm_h <= 1'b0;
            r_pwm_l <= 1'b0;
            r_fault <= 1'b0;
            if (fault) begin
                r_state <= FAULT;
                r_cnt   <= '0;
                r_fault <= 1'b1;
            end else if (r_state == FAULT) begin
                if (fault_clear) begin
                    r_state <= OFF;
                end else begin
                    r_state <= FAULT;
                    r_fault <= 1'b1;
                end
            end else if (!enable) begin
                r_state <= OFF;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    OFF: begin
                        if (r_pwm_q) begin
                            r_state <= DT_LH;
                            r_cnt   <= w_rise_load;
                        end else begin
                            r_state <= DT_HL;
                            r_cnt   <= w_fall_load;
                        end
                    end
                    DT_LH: begin
                        if (!r_pwm_q) begin
                            r_state <= LOW_ON;
                            r_cnt   <= '0;
                            r_pwm_l <= 1'b1;
                        end else if (r_cnt == '0) begin
                            r_state <= HIGH_ON;
                            r_pwm_h <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - W'(1);
                        end
                    end
                    HIGH_ON: begin
                        if (!r_pwm_q) begin
                            r_state <= DT_HL;
                            r_cnt   <= w_fall_load;
                        end else begin
                            r_pwm_h <= 1'b1;
                        end
                    end
                    DT_HL: begin
                        if (r_pwm_q) begin
                            r_state <= HIGH_ON;
                            r_cnt   <= '0;
                            r_pwm_h <= 1'b1;
                        end else if (r_cnt == '0) begin
                            r_state <= LOW_ON;
                            r_pwm_l <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - W'(1);
                        end
                    end
                    LOW_ON: begin
                        if (r_pwm_q) begin
                            r_state <= DT_LH;
                            r_cnt   <= w_rise_load;
                        end else begin
                            r_pwm_l <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= OFF;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign pwm_h         = r_pwm_h;
    assign pwm_l         = r_pwm_l;
    assign fault_latched = r_fault;
    assign state         = r_state;

endmodule

// File: tb/tb_deadtime_generator.sv
// Directed and randomized checks for the dead-time gate driver.
module tb_deadtime_generator;
    import deadtime_generator_pkg::*;

    localparam int W      = 8;
    localparam int MIN_DT = 1;

    logic         aclk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         pwm = 1'b0;
    logic [W-1:0] deadtime_rise = '0;
    logic [W-1:0] deadtime_fall = '0;
    logic         fault = 1'b0;
    logic         fault_clear = 1'b0;
    logic         pwm_h;
    logic         pwm_l;
    logic         fault_latched;
    logic [2:0]   state;

    int vectors = 0;
    int miscompares = 0;

    deadtime_generator #(
        .deadtime_width(W),
        .min_deadtime(MIN_DT)
    ) dut (
        .aclk(aclk),
        .reset(reset),
        .enable(enable),
        .pwm(pwm),
        .deadtime_rise(deadtime_rise),
        .deadtime_fall(deadtime_fall),
        .fault(fault),
        .fault_clear(fault_clear),
        .pwm_h(pwm_h),
        .pwm_l(pwm_l),
        .fault_latched(fault_latched),
        .state(state)
    );

    always #5 aclk = ~aclk;

    // Gate non-overlap invariant
    always @(negedge aclk) begin
        assert (!(pwm_h && pwm_l))
        else $error("FAIL overlap_assert: pwm_h=%b pwm_l=%b", pwm_h, pwm_l);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int dlen(input logic [W-1:0] f);
        return (int'(f) < MIN_DT) ? MIN_DT : int'(f);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({state, pwm_h, pwm_l, fault_latched} !== {3'(OFF), 3'b000}) begin
            miscompares++;
            $display("FAIL reset: state=%0d h=%b l=%b f=%b want 0 0 0 0",
                     state, pwm_h, pwm_l, fault_latched);
        end
        reset = 1'b0;
    endtask

    task automatic test_startup_low();
        enable = 1'b1;
        deadtime_rise = 8'd5;
        deadtime_fall = 8'd3;
        pwm = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            vectors++;
            if (pwm_h !== 1'b0 || pwm_l !== (i == 4)) begin
                miscompares++;
                $display("FAIL startup c%0d: h=%b l=%b want 0 %b",
                         i, pwm_h, pwm_l, i == 4);
            end
            if (i == 1) begin
                vectors++;
                if (state !== DT_HL) begin
                    miscompares++;
                    $display("FAIL startup_state: got %0d want %0d", state, DT_HL);
                end
            end
        end
    endtask

    task automatic test_edges();
        pwm = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            vectors++;
            if (pwm_h !== (i == 7) || pwm_l !== (i == 1)) begin
                miscompares++;
                $display("FAIL rise c%0d: h=%b l=%b want %b %b",
                         i, pwm_h, pwm_l, i == 7, i == 1);
            end
        end
        pwm = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (pwm_h !== (i == 1) || pwm_l !== (i == 5)) begin
                miscompares++;
                $display("FAIL fall c%0d: h=%b l=%b want %b %b",
                         i, pwm_h, pwm_l, i == 1, i == 5);
            end
        end
    endtask

    task automatic test_min_deadtime();
        deadtime_rise = 8'd0;
        pwm = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (pwm_h !== (i == 3) || pwm_l !== (i == 1)) begin
                miscompares++;
                $display("FAIL mindt c%0d: h=%b l=%b want %b %b",
                         i, pwm_h, pwm_l, i == 3, i == 1);
            end
        end
        pwm = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        vectors++;
        if (pwm_l !== 1'b1) begin
            miscompares++;
            $display("FAIL mindt_return: l=%b want 1", pwm_l);
        end
        deadtime_rise = 8'd5;
    endtask

    task automatic test_abort();
        logic exp_l;
        deadtime_rise = 8'd10;
        pwm = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) pwm = 1'b0;
            tick();
            exp_l = (i == 1) || (i >= 6);
            vectors++;
            if (pwm_h !== 1'b0 || pwm_l !== exp_l) begin
                miscompares++;
                $display("FAIL abort c%0d: h=%b l=%b want 0 %b",
                         i, pwm_h, pwm_l, exp_l);
            end
            if (i == 2 || i == 6) begin
                vectors++;
                if (state !== ((i == 2) ? 3'(DT_LH) : 3'(LOW_ON))) begin
                    miscompares++;
                    $display("FAIL abort_state c%0d: got %0d", i, state);
                end
            end
        end
        deadtime_rise = 8'd5;
    endtask

    task automatic test_fault();
        pwm = 1'b1;
        for (int i = 1; i <= 7; i++) tick();
        vectors++;
        if (pwm_h !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_pre: h=%b want 1", pwm_h);
        end
        fault = 1'b1;
        tick();
        fault = 1'b0;
        vectors++;
        if ({pwm_h, pwm_l, fault_latched, state} !== {3'b001, 3'(FAULT)}) begin
            miscompares++;
            $display("FAIL fault_entry: h=%b l=%b f=%b st=%0d want 0 0 1 5",
                     pwm_h, pwm_l, fault_latched, state);
        end
        fault = 1'b1;
        fault_clear = 1'b1;
        tick();
        vectors++;
        if (fault_latched !== 1'b1 || state !== FAULT) begin
            miscompares++;
            $display("FAIL fault_hold: f=%b st=%0d want 1 5", fault_latched, state);
        end
        fault = 1'b0;
        tick();
        fault_clear = 1'b0;
        vectors++;
        if ({pwm_h, pwm_l, fault_latched, state} !== {3'b000, 3'(OFF)}) begin
            miscompares++;
            $display("FAIL fault_clear: h=%b l=%b f=%b st=%0d want 0 0 0 0",
                     pwm_h, pwm_l, fault_latched, state);
        end
        tick();
        vectors++;
        if (state !== DT_LH) begin
            miscompares++;
            $display("FAIL fault_resume: st=%0d want %0d", state, DT_LH);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (pwm_h !== (i == 5) || pwm_l !== 1'b0) begin
                miscompares++;
                $display("FAIL resume c%0d: h=%b l=%b want %b 0",
                         i, pwm_h, pwm_l, i == 5);
            end
        end
    endtask

    task automatic test_enable_off();
        enable = 1'b0;
        tick();
        vectors++;
        if ({pwm_h, pwm_l, state} !== {2'b00, 3'(OFF)}) begin
            miscompares++;
            $display("FAIL disable: h=%b l=%b st=%0d want 0 0 0",
                     pwm_h, pwm_l, state);
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0] prev_state;
        int off_run;
        int cur_d;
        int hold;
        prev_state = state;
        off_run = 0;
        cur_d = MIN_DT;
        hold = 0;
        for (int c = 0; c < 10000; c++) begin
            if (hold == 0) begin
                pwm = ~pwm;
                hold = $urandom_range(1, 20);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) deadtime_rise = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) deadtime_fall = 8'($urandom_range(0, 12));
            enable = ($urandom_range(0, 299) != 0);
            fault = ($urandom_range(0, 799) == 0);
            fault_clear = ($urandom_range(0, 9) == 0);
            tick();
            vectors++;
            if (pwm_h && pwm_l) begin
                miscompares++;
                $display("FAIL overlap c%0d: h=%b l=%b", c, pwm_h, pwm_l);
            end
            if (state != prev_state && state == DT_LH) cur_d = dlen(deadtime_rise);
            if (state != prev_state && state == DT_HL) cur_d = dlen(deadtime_fall);
            if (!pwm_h && !pwm_l) begin
                off_run++;
            end else begin
                if ((pwm_h && prev_state == DT_LH) || (pwm_l && prev_state == DT_HL)) begin
                    vectors++;
                    if (off_run < cur_d) begin
                        miscompares++;
                        $display("FAIL dead_gap c%0d: gap=%0d want >= %0d",
                                 c, off_run, cur_d);
                    end
                end
                off_run = 0;
            end
            prev_state = state;
        end
        fault = 1'b0;
        fault_clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        reset = 1'b1;
        tick();
        vectors++;
        if ({pwm_h, pwm_l, fault_latched, state} !== {3'b000, 3'(OFF)}) begin
            miscompares++;
            $display("FAIL reset_mid: h=%b l=%b f=%b st=%0d want 0 0 0 0",
                     pwm_h, pwm_l, fault_latched, state);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup_low();
        test_edges();
        test_min_deadtime();
        test_abort();
        test_fault();
        test_enable_off();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
